// File: rtl/prefetch_store_buffer_pkg.sv
// Shared definitions for the prefetch store buffer.
//   rd_state_e : read FSM states
//   NLANES     : lanes per write/read stream
//   ptr_add    : wrap-around add for the allocation pointer
package prefetch_store_buffer_pkg;

  localparam int NLANES = 2;

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} rd_state_e;

  // Entry layout is {valid, addr, data}. The width-specific struct lives in
  // the top because AW/DW are module parameters.

  function automatic int unsigned ptr_add(input int unsigned p, input int unsigned n,
                                          input int unsigned depth);
    return (p + n) % depth;
  endfunction

endpackage

// File: rtl/prefetch_store_buffer_psb_match.sv
// psb_match: combinational fully-associative address compare.
//   valid_i/addr_i/data_i : flattened entry array
//   key_i                 : address to look up
//   hit_vec_o             : one-hot hit vector (entries are address-unique)
//   hit_o / data_o        : any-hit flag and selected data (0 on miss)
module psb_match #(
  parameter int DEPTH = 16,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic [DEPTH-1:0]         valid_i,
  input  logic [DEPTH-1:0][AW-1:0] addr_i,
  input  logic [DEPTH-1:0][DW-1:0] data_i,
  input  logic [AW-1:0]            key_i,
  output logic [DEPTH-1:0]         hit_vec_o,
  output logic                     hit_o,
  output logic [DW-1:0]            data_o
);

  always_comb begin
    hit_vec_o = '0;
    data_o    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_vec_o[i] = valid_i[i] && (addr_i[i] == key_i);
      // OR-select; a miss leaves data_o at zero.
      if (hit_vec_o[i]) data_o = data_o | data_i[i];
    end
    hit_o = |hit_vec_o;
  end

endmodule

// File: rtl/prefetch_store_buffer.sv
// prefetch_store_buffer: two-lane address-tagged store buffer, FIFO replacement.
//   clk, reset                 : clock, synchronous active-high reset
//   wren_i/w_addr_i/w_data_i   : per-lane write stream (lane 0 before lane 1)
//   data_req_i, r_addr_i       : dual-lane read request, accepted when wait_o=0
//   wait_o, data_ready_o       : busy flag, one-cycle response strobe
//   data_o, hit_o              : per-lane read data (0 on miss) and hit flag
//   flush_i                    : invalidate everything, drop same-cycle writes
//   occupancy_o                : number of valid entries
module prefetch_store_buffer
  import prefetch_store_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NLANES-1:0]             wren_i,
  input  logic [NLANES-1:0][AW-1:0]     w_addr_i,
  input  logic [NLANES-1:0][DW-1:0]     w_data_i,
  input  logic                          data_req_i,
  input  logic [NLANES-1:0][AW-1:0]     r_addr_i,
  output logic                          wait_o,
  output logic                          data_ready_o,
  output logic [NLANES-1:0][DW-1:0]     data_o,
  output logic [NLANES-1:0]             hit_o,
  input  logic                          flush_i,
  output logic [$clog2(DEPTH):0]        occupancy_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int OW = IW + 1;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t [DEPTH-1:0] ents_q, ents_mid, ents_d;
  logic   [IW-1:0]    ptr_q, ptr_mid, ptr_d;
  logic   [OW-1:0]    occ_q, occ_mid, occ_d;

  // Flattened views for the matchers: committed state and post-lane-0 state.
  logic [DEPTH-1:0]         vld_q, vld_mid;
  logic [DEPTH-1:0][AW-1:0] adr_q, adr_mid;
  logic [DEPTH-1:0][DW-1:0] dat_q, dat_mid;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      vld_q[i]   = ents_q[i].valid;
      adr_q[i]   = ents_q[i].addr;
      dat_q[i]   = ents_q[i].data;
      vld_mid[i] = ents_mid[i].valid;
      adr_mid[i] = ents_mid[i].addr;
      dat_mid[i] = ents_mid[i].data;
    end
  end

  // ---------------- write path ----------------
  logic [DEPTH-1:0] w0_vec, w1_vec;
  logic             w0_hit, w1_hit;
  logic [DW-1:0]    wr0_data_unused, wr1_data_unused;

  psb_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_wr0 (
    .valid_i(vld_q), .addr_i(adr_q), .data_i(dat_q), .key_i(w_addr_i[0]),
    .hit_vec_o(w0_vec), .hit_o(w0_hit), .data_o(wr0_data_unused)
  );

  // Lane 1 matches against the array as lane 0 left it, so an address
  // lane 0 just allocated is a hit for lane 1.
  psb_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_wr1 (
    .valid_i(vld_mid), .addr_i(adr_mid), .data_i(dat_mid), .key_i(w_addr_i[1]),
    .hit_vec_o(w1_vec), .hit_o(w1_hit), .data_o(wr1_data_unused)
  );

  always_comb begin
    ents_mid = ents_q;
    ptr_mid  = ptr_q;
    occ_mid  = occ_q;
    if (wren_i[0]) begin
      if (w0_hit) begin
        for (int i = 0; i < DEPTH; i++)
          if (w0_vec[i]) ents_mid[i].data = w_data_i[0];
      end else begin
        ents_mid[ptr_q] = '{valid: 1'b1, addr: w_addr_i[0], data: w_data_i[0]};
        ptr_mid = IW'(ptr_add(ptr_q, 1, DEPTH));
        if (occ_q != OW'(DEPTH)) occ_mid = occ_q + 1'b1;
      end
    end
  end

  always_comb begin
    ents_d = ents_mid;
    ptr_d  = ptr_mid;
    occ_d  = occ_mid;
    if (wren_i[1]) begin
      if (w1_hit) begin
        for (int i = 0; i < DEPTH; i++)
          if (w1_vec[i]) ents_d[i].data = w_data_i[1];
      end else begin
        ents_d[ptr_mid] = '{valid: 1'b1, addr: w_addr_i[1], data: w_data_i[1]};
        ptr_d = IW'(ptr_add(ptr_mid, 1, DEPTH));
        if (occ_mid != OW'(DEPTH)) occ_d = occ_mid + 1'b1;
      end
    end
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) ents_d[i].valid = 1'b0;
      ptr_d = '0;
      occ_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ents_q[i].valid <= 1'b0;
      ptr_q <= '0;
      occ_q <= '0;
    end else begin
      ents_q <= ents_d;
      ptr_q  <= ptr_d;
      occ_q  <= occ_d;
    end
  end

  assign occupancy_o = occ_q;

  // ---------------- read path ----------------
  rd_state_e                   state_q;
  logic [NLANES-1:0][AW-1:0]   raddr_q;
  logic [NLANES-1:0][DW-1:0]   rd_data, data_q;
  logic [NLANES-1:0]           rd_hit, hit_q;
  logic [NLANES-1:0][DEPTH-1:0] rd_vec_unused;
  logic                        wait_q, rdy_q;

  // Lookup uses the committed array, so writes landing in the LOOKUP
  // cycle are not seen by this read.
  for (genvar l = 0; l < NLANES; l++) begin : g_rd
    psb_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_rd (
      .valid_i(vld_q), .addr_i(adr_q), .data_i(dat_q), .key_i(raddr_q[l]),
      .hit_vec_o(rd_vec_unused[l]), .hit_o(rd_hit[l]), .data_o(rd_data[l])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      raddr_q <= '0;
      data_q  <= '0;
      hit_q   <= '0;
      wait_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (data_req_i) begin
          raddr_q <= r_addr_i;
          wait_q  <= 1'b1;
          state_q <= LOOKUP;
        end
        LOOKUP: begin
          data_q  <= rd_data;
          hit_q   <= rd_hit;
          rdy_q   <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          rdy_q   <= 1'b0;
          wait_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wait_o       = wait_q;
  assign data_ready_o = rdy_q;
  assign data_o       = data_q;
  assign hit_o        = hit_q;

endmodule

// File: tb/tb_prefetch_store_buffer.sv
module tb_prefetch_store_buffer;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       wren_i;
  logic [1:0][31:0] w_addr_i, w_data_i, r_addr_i;
  logic             data_req_i, flush_i;
  logic             wait_o, data_ready_o;
  logic [1:0][31:0] data_o;
  logic [1:0]       hit_o;
  logic [4:0]       occupancy_o;

  int checks = 0;
  int errors = 0;

  prefetch_store_buffer #(.DEPTH(16), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .wren_i(wren_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
    .data_req_i(data_req_i), .r_addr_i(r_addr_i),
    .wait_o(wait_o), .data_ready_o(data_ready_o),
    .data_o(data_o), .hit_o(hit_o),
    .flush_i(flush_i), .occupancy_o(occupancy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wr(input logic e0, input logic [31:0] a0, input logic [31:0] d0,
                    input logic e1, input logic [31:0] a1, input logic [31:0] d1);
    wren_i = {e1, e0};
    w_addr_i[0] = a0; w_data_i[0] = d0;
    w_addr_i[1] = a1; w_data_i[1] = d1;
    tick();
    wren_i = 2'b00;
  endtask

  // Full read transaction: accept edge, LOOKUP, RESP, back to IDLE.
  task automatic read2(input string tag, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] e0, input logic [31:0] e1,
                       input logic eh0, input logic eh1);
    data_req_i = 1'b1;
    r_addr_i[0] = a0;
    r_addr_i[1] = a1;
    tick();
    data_req_i = 1'b0;
    chk({tag, ".lookup_wait"}, 64'(wait_o), 64'd1);
    chk({tag, ".lookup_rdy"}, 64'(data_ready_o), 64'd0);
    tick();
    chk({tag, ".rdy"}, 64'(data_ready_o), 64'd1);
    chk({tag, ".d0"}, 64'(data_o[0]), 64'(e0));
    chk({tag, ".d1"}, 64'(data_o[1]), 64'(e1));
    chk({tag, ".h0"}, 64'(hit_o[0]), 64'(eh0));
    chk({tag, ".h1"}, 64'(hit_o[1]), 64'(eh1));
    tick();
    chk({tag, ".idle_rdy"}, 64'(data_ready_o), 64'd0);
    chk({tag, ".idle_wait"}, 64'(wait_o), 64'd0);
  endtask

  initial begin
    reset = 1'b0; wren_i = '0; w_addr_i = '0; w_data_i = '0;
    data_req_i = 1'b0; r_addr_i = '0; flush_i = 1'b0;

    // Reset state
    do_reset();
    chk("rst.wait", 64'(wait_o), 64'd0);
    chk("rst.rdy", 64'(data_ready_o), 64'd0);
    chk("rst.data", 64'(data_o), 64'd0);
    chk("rst.hit", 64'(hit_o), 64'd0);
    chk("rst.occ", 64'(occupancy_o), 64'd0);

    // Basic hit/miss
    wr(1, 32'h100, 32'hAA, 0, 32'h0, 32'h0);
    chk("basic.occ", 64'(occupancy_o), 64'd1);
    read2("basic", 32'h100, 32'h104, 32'hAA, 32'h0, 1'b1, 1'b0);

    // Same address on both lanes -> one entry with lane 1 data
    do_reset();
    wr(1, 32'h200, 32'h1, 1, 32'h200, 32'h2);
    chk("same.occ", 64'(occupancy_o), 64'd1);
    read2("same", 32'h200, 32'h200, 32'h2, 32'h2, 1'b1, 1'b1);

    // Two distinct misses, then lane 1 hitting an existing entry
    do_reset();
    wr(1, 32'h10, 32'h11, 1, 32'h20, 32'h22);
    chk("pair.occ", 64'(occupancy_o), 64'd2);
    read2("pair", 32'h10, 32'h20, 32'h11, 32'h22, 1'b1, 1'b1);
    wr(1, 32'h30, 32'h33, 1, 32'h10, 32'h99);
    chk("pair2.occ", 64'(occupancy_o), 64'd3);
    read2("pair2", 32'h10, 32'h30, 32'h99, 32'h33, 1'b1, 1'b1);

    // Fill past capacity: 17 writes, oldest (0x0) evicted
    do_reset();
    for (int i = 0; i < 17; i++) wr(1, 32'(i * 4), 32'h1000 + 32'(i), 0, 32'h0, 32'h0);
    chk("full.occ", 64'(occupancy_o), 64'd16);
    read2("full", 32'h0, 32'h40, 32'h0, 32'h1010, 1'b0, 1'b1);
    read2("full2", 32'h4, 32'h3C, 32'h1001, 32'h100F, 1'b1, 1'b1);
    wr(1, 32'h44, 32'h1011, 0, 32'h0, 32'h0);
    chk("full.occ_sat", 64'(occupancy_o), 64'd16);
    read2("full3", 32'h4, 32'h44, 32'h0, 32'h1011, 1'b0, 1'b1);

    // Write in request cycle is seen; write in LOOKUP cycle is not
    do_reset();
    data_req_i = 1'b1;
    r_addr_i[0] = 32'h300; r_addr_i[1] = 32'h304;
    wren_i = 2'b01; w_addr_i[0] = 32'h300; w_data_i[0] = 32'h33;
    tick();
    data_req_i = 1'b0;
    w_addr_i[0] = 32'h304; w_data_i[0] = 32'h44;
    tick();
    wren_i = 2'b00;
    chk("race.rdy", 64'(data_ready_o), 64'd1);
    chk("race.h0", 64'(hit_o[0]), 64'd1);
    chk("race.d0", 64'(data_o[0]), 64'h33);
    chk("race.h1", 64'(hit_o[1]), 64'd0);
    chk("race.d1", 64'(data_o[1]), 64'd0);
    tick();
    read2("race2", 32'h304, 32'h300, 32'h44, 32'h33, 1'b1, 1'b1);

    // Continuous request: wait 0,1,1 and ready on every third cycle
    data_req_i = 1'b1;
    r_addr_i[0] = 32'h300; r_addr_i[1] = 32'h304;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("cont.wait%0d", i), 64'(wait_o), ((i % 3) != 0) ? 64'd1 : 64'd0);
      chk($sformatf("cont.rdy%0d", i), 64'(data_ready_o), ((i % 3) == 2) ? 64'd1 : 64'd0);
      tick();
    end
    data_req_i = 1'b0;
    tick();

    // Flush during LOOKUP: read completes with pre-flush data
    data_req_i = 1'b1;
    tick();
    data_req_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush.rdy", 64'(data_ready_o), 64'd1);
    chk("flush.d0", 64'(data_o[0]), 64'h33);
    chk("flush.d1", 64'(data_o[1]), 64'h44);
    chk("flush.occ", 64'(occupancy_o), 64'd0);
    tick();
    // Flush drops a same-cycle write
    flush_i = 1'b1;
    wr(1, 32'h500, 32'h55, 0, 32'h0, 32'h0);
    flush_i = 1'b0;
    chk("flush.drop_occ", 64'(occupancy_o), 64'd0);
    read2("flush2", 32'h300, 32'h500, 32'h0, 32'h0, 1'b0, 1'b0);

    // Reset during LOOKUP aborts the read
    wr(1, 32'h600, 32'h66, 0, 32'h0, 32'h0);
    read2("prerst", 32'h600, 32'h600, 32'h66, 32'h66, 1'b1, 1'b1);
    data_req_i = 1'b1;
    tick();
    data_req_i = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst.wait", 64'(wait_o), 64'd0);
    chk("midrst.rdy", 64'(data_ready_o), 64'd0);
    chk("midrst.data", 64'(data_o), 64'd0);
    chk("midrst.hit", 64'(hit_o), 64'd0);
    chk("midrst.occ", 64'(occupancy_o), 64'd0);
    tick();
    chk("midrst.rdy2", 64'(data_ready_o), 64'd0);
    tick();
    chk("midrst.rdy3", 64'(data_ready_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
